// File: rtl/usrt_tx_arbiter_if.sv
// Signal bundle between usrt_tx_arbiter, the two message sources and the USRT transmitter.
// master: the arbiter side; slave: sources, transmitter and control seen from outside.
interface usrt_tx_arbiter_if #(
    parameter int unsigned DATA_W = 8
);
    logic              rr_mode;
    logic [1:0]        req;
    logic [DATA_W-1:0] src_data0;
    logic [DATA_W-1:0] src_data1;
    logic [1:0]        src_last;
    logic [1:0]        gnt;
    logic [1:0]        byte_rd;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_busy;
    logic              rts;
    logic              abort;
    logic [15:0]       frm_cnt0;
    logic [15:0]       frm_cnt1;

    modport master (
        input  rr_mode,
        input  req,
        input  src_data0,
        input  src_data1,
        input  src_last,
        input  tx_busy,
        output gnt,
        output byte_rd,
        output tx_data,
        output tx_load,
        output rts,
        output abort,
        output frm_cnt0,
        output frm_cnt1
    );

    modport slave (
        output rr_mode,
        output req,
        output src_data0,
        output src_data1,
        output src_last,
        output tx_busy,
        input  gnt,
        input  byte_rd,
        input  tx_data,
        input  tx_load,
        input  rts,
        input  abort,
        input  frm_cnt0,
        input  frm_cnt1
    );
endinterface

// File: rtl/usrt_tx_arbiter.sv
// Shares one USRT transmitter between two frame sources: arbitrate, hold rts, feed bytes.
// Per-source completed-frame counters are built only when USRT_ARB_STATS_EN is defined.
module usrt_tx_arbiter #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RTS_SETUP  = 4,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned MAX_BYTES  = 64
) (
    input logic               clk,
    input logic               rst,
    usrt_tx_arbiter_if.master bus
);

    localparam int unsigned CntMax = (RTS_SETUP > GAP_CYCLES) ? RTS_SETUP : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);

    localparam logic [CntW-1:0] SetupEnd = CntW'(RTS_SETUP);
    localparam logic [CntW-1:0] GapEnd   = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [6:0]      ByteCap  = 7'(MAX_BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLoad,
        StAck,
        StDone,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      byte_cnt_q, byte_cnt_d;
    logic            last_q, last_d;
    logic            win_q, win_d;
    logic            ptr_q, ptr_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            rts_q, rts_d;
    logic            abort_q, abort_d;
    logic            frame_done;
    logic            pick;
    logic            load;
    logic [DATA_W-1:0] sel_data;

    // Round-robin favours ptr_q; fixed priority always favours source 0.
    always_comb begin
        if (bus.rr_mode) begin
            pick = bus.req[ptr_q] ? ptr_q : ~ptr_q;
        end else begin
            pick = bus.req[0] ? 1'b0 : 1'b1;
        end
    end

    assign load     = (state_q == StLoad);
    assign sel_data = win_q ? bus.src_data1 : bus.src_data0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        last_d     = last_q;
        win_d      = win_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        rts_d      = rts_q;
        abort_d    = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req != 2'b00) begin
                    win_d      = pick;
                    ptr_d      = ~pick;
                    gnt_d      = pick ? 2'b10 : 2'b01;
                    cnt_d      = '0;
                    byte_cnt_d = '0;
                    last_d     = 1'b0;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                rts_d = 1'b1;
                if (cnt_q == SetupEnd) begin
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StLoad: begin
                last_d     = bus.src_last[win_q];
                byte_cnt_d = byte_cnt_q + 7'd1;
                state_d    = StAck;
            end
            StAck: begin
                if (bus.tx_busy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!bus.tx_busy) begin
                    if (last_q || (byte_cnt_q == ByteCap)) begin
                        // Only a frame that ended on its own last byte is counted.
                        frame_done = last_q;
                        abort_d    = ~last_q;
                        rts_d      = 1'b0;
                        gnt_d      = 2'b00;
                        cnt_d      = '0;
                        state_d    = StGap;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapEnd) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            last_q     <= 1'b0;
            win_q      <= 1'b0;
            ptr_q      <= 1'b0;
            gnt_q      <= 2'b00;
            rts_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            last_q     <= last_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rts_q      <= rts_d;
            abort_q    <= abort_d;
        end
    end

    // Load strobe, byte_rd and data are decoded from the LOAD state so they stay coincident.
    assign bus.gnt     = gnt_q;
    assign bus.rts     = rts_q;
    assign bus.abort   = abort_q;
    assign bus.tx_load = load;
    assign bus.byte_rd = load ? gnt_q : 2'b00;
    assign bus.tx_data = load ? sel_data : '0;

`ifdef USRT_ARB_STATS_EN
    logic [15:0] frm_cnt0_q;
    logic [15:0] frm_cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt0_q <= '0;
            frm_cnt1_q <= '0;
        end else if (frame_done) begin
            if (win_q) begin
                frm_cnt1_q <= frm_cnt1_q + 16'd1;
            end else begin
                frm_cnt0_q <= frm_cnt0_q + 16'd1;
            end
        end
    end

    assign bus.frm_cnt0 = frm_cnt0_q;
    assign bus.frm_cnt1 = frm_cnt1_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
    assign bus.frm_cnt0      = '0;
    assign bus.frm_cnt1      = '0;
`endif

endmodule

// File: tb/tb_usrt_tx_arbiter.sv
// Scoreboard bench for usrt_tx_arbiter: directed frames, models of sources and transmitter.
`timescale 1ns/1ps
module tb_usrt_tx_arbiter;

    localparam int DATA_W = 8;

`ifdef USRT_ARB_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usrt_tx_arbiter_if #(.DATA_W(DATA_W)) bus ();

    usrt_tx_arbiter #(
        .DATA_W    (DATA_W),
        .RTS_SETUP (4),
        .GAP_CYCLES(16),
        .MAX_BYTES (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } sbyte_t;

    typedef struct {
        int         src;
        logic [7:0] d;
    } load_t;

    sbyte_t src_q0[$];
    sbyte_t src_q1[$];
    load_t  exp_load_q[$];
    int     exp_gnt_q[$];
    int     exp_len_q[$];
    int     exp_abt_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int tot_grants  = 0;
    int tot_loads   = 0;
    int tot_frames  = 0;

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Transmitter: busy for 15 clk starting the cycle after each load.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_load) busy_cnt <= 15;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    // Sources: present queue head, advance on byte_rd.
    always @(posedge clk) begin
        if (bus.byte_rd[0] && src_q0.size() != 0) void'(src_q0.pop_front());
        if (bus.byte_rd[1] && src_q1.size() != 0) void'(src_q1.pop_front());
    end
    always @(negedge clk) begin
        bus.src_data0   = (src_q0.size() != 0) ? src_q0[0].d : 8'h00;
        bus.src_data1   = (src_q1.size() != 0) ? src_q1[0].d : 8'h00;
        bus.src_last[0] = (src_q0.size() != 0) ? src_q0[0].l : 1'b0;
        bus.src_last[1] = (src_q1.size() != 0) ? src_q1[0].l : 1'b0;
    end

    // Monitor
    int         cyc = 0;
    int         gnt_cyc = 0;
    int         rts_cyc = 0;
    int         fall_cyc = 0;
    bit         have_fall = 0;
    bit         abt_next = 0;
    bit         rts_fall;
    int         loads = 0;
    int         mon_i;
    load_t      mon_e;
    logic [1:0] prev_gnt = 2'b00;
    logic       prev_rts = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            have_fall = 0;
            abt_next  = 0;
            loads     = 0;
            prev_gnt  = 2'b00;
            prev_rts  = 1'b0;
        end else begin
            if (abt_next) begin
                chk("abort_width", int'(bus.abort), 0);
                abt_next = 0;
            end
            if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
                tot_grants++;
                gnt_cyc = cyc;
                loads   = 0;
                chk("grant_expected", int'(exp_gnt_q.size() != 0), 1);
                if (exp_gnt_q.size() != 0) begin
                    mon_i = exp_gnt_q.pop_front();
                    chk("grant_src", int'(bus.gnt), (mon_i == 0) ? 1 : 2);
                end
                if (have_fall) chk("gap_min16", int'((cyc - fall_cyc) >= 16), 1);
            end
            if (bus.rts && !prev_rts) begin
                rts_cyc = cyc;
                chk("rts_after_grant", cyc - gnt_cyc, 1);
            end
            if (bus.tx_load || bus.byte_rd != 2'b00)
                chk("byte_rd_with_load", int'(bus.byte_rd), bus.tx_load ? int'(bus.gnt) : 0);
            if (bus.tx_load) begin
                tot_loads++;
                loads++;
                if (loads == 1) chk("first_load_after_rts", cyc - rts_cyc, 4);
                chk("load_expected", int'(exp_load_q.size() != 0), 1);
                if (exp_load_q.size() != 0) begin
                    mon_e = exp_load_q.pop_front();
                    chk("tx_data", int'(bus.tx_data), int'(mon_e.d));
                    chk("load_src", int'(bus.gnt), (mon_e.src == 0) ? 1 : 2);
                end
            end
            rts_fall = prev_rts && !bus.rts;
            if (bus.abort) chk("abort_with_rts_fall", int'(rts_fall), 1);
            if (rts_fall) begin
                tot_frames++;
                fall_cyc  = cyc;
                have_fall = 1;
                abt_next  = 1;
                chk("gnt_clear_at_gap", int'(bus.gnt), 0);
                chk("frame_expected", int'(exp_len_q.size() != 0), 1);
                if (exp_len_q.size() != 0) begin
                    mon_i = exp_len_q.pop_front();
                    chk("frame_len", loads, mon_i);
                    mon_i = exp_abt_q.pop_front();
                    chk("abort_at_gap", int'(bus.abort), mon_i);
                end
            end
            prev_gnt = bus.gnt;
            prev_rts = bus.rts;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_byte(input int src, input logic [7:0] d, input bit last, input bit exp_ld);
        sbyte_t b;
        load_t  e;
        b.d = d;
        b.l = last;
        if (src == 0) src_q0.push_back(b);
        else src_q1.push_back(b);
        if (exp_ld) begin
            e.src = src;
            e.d   = d;
            exp_load_q.push_back(e);
        end
    endtask

    // n consecutive bytes starting at first, last flag on the final one.
    task automatic add_seq(input int src, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) add_byte(src, first + 8'(i), i == n - 1, 1'b1);
    endtask

    task automatic add_frame(input int src, input int len, input int abt);
        exp_gnt_q.push_back(src);
        exp_len_q.push_back(len);
        exp_abt_q.push_back(abt);
    endtask

    task automatic wait_for(input string what, input int which, input int target, input int budget);
        int v;
        for (int i = 0; i < budget; i++) begin
            v = (which == 0) ? tot_grants : (which == 1) ? tot_loads : tot_frames;
            if (v >= target) break;
            @(posedge clk);
        end
        v = (which == 0) ? tot_grants : (which == 1) ? tot_loads : tot_frames;
        if (v < target) chk({what, "_timeout"}, v, target);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, int'(bus.gnt), 0);
        chk({tag, "_byte_rd"}, int'(bus.byte_rd), 0);
        chk({tag, "_tx_data"}, int'(bus.tx_data), 0);
        chk({tag, "_tx_load"}, int'(bus.tx_load), 0);
        chk({tag, "_rts"}, int'(bus.rts), 0);
        chk({tag, "_abort"}, int'(bus.abort), 0);
        chk({tag, "_frm_cnt0"}, int'(bus.frm_cnt0), 0);
        chk({tag, "_frm_cnt1"}, int'(bus.frm_cnt1), 0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 2'b00;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int f;
        int l;
        int c1;
        bus.req     = 2'b00;
        bus.rr_mode = 1'b0;
        rst         = 1'b1;
        tick(3);
        check_zero("reset");
        rst = 1'b0;

        // Basic 3-byte frame from source 0.
        add_seq(0, 8'hA1, 3);
        add_frame(0, 3, 0);
        bus.req = 2'b01;
        wait_for("t1_grant", 0, 1, 50);
        bus.req = 2'b00;
        wait_for("t1_frame", 2, 1, 200);
        tick(20);

        // Fixed priority: source 0 takes every grant.
        do_reset();
        bus.rr_mode = 1'b0;
        add_seq(0, 8'hB0, 2);
        add_frame(0, 2, 0);
        add_seq(0, 8'hC0, 1);
        add_frame(0, 1, 0);
        add_seq(0, 8'hD0, 3);
        add_frame(0, 3, 0);
        g       = tot_grants;
        f       = tot_frames;
        bus.req = 2'b11;
        wait_for("fixed_grants", 0, g + 3, 600);
        bus.req = 2'b00;
        wait_for("fixed_frames", 2, f + 3, 800);
        tick(20);
        chk("fixed_frm_cnt0", int'(bus.frm_cnt0), Stats ? 3 : 0);
        chk("fixed_frm_cnt1", int'(bus.frm_cnt1), 0);

        // Round-robin: 0,1,0,1.
        do_reset();
        bus.rr_mode = 1'b1;
        add_seq(0, 8'h10, 1);
        add_frame(0, 1, 0);
        add_seq(1, 8'h20, 2);
        add_frame(1, 2, 0);
        add_seq(0, 8'h30, 1);
        add_frame(0, 1, 0);
        add_seq(1, 8'h40, 3);
        add_frame(1, 3, 0);
        g       = tot_grants;
        f       = tot_frames;
        bus.req = 2'b11;
        wait_for("rr_grants", 0, g + 4, 800);
        bus.req = 2'b00;
        wait_for("rr_frames", 2, f + 4, 900);
        tick(20);
        chk("rr_frm_cnt0", int'(bus.frm_cnt0), Stats ? 2 : 0);
        chk("rr_frm_cnt1", int'(bus.frm_cnt1), Stats ? 2 : 0);

        // Source 1 never flags last: cut at 64 bytes.
        c1 = int'(bus.frm_cnt1);
        for (int i = 0; i < 64; i++) add_byte(1, 8'(i * 3 + 1), 1'b0, 1'b1);
        add_frame(1, 64, 1);
        f       = tot_frames;
        bus.req = 2'b10;
        wait_for("abort_grant", 0, tot_grants + 1, 50);
        bus.req = 2'b00;
        wait_for("abort_frame", 2, f + 1, 1500);
        tick(20);
        chk("abort_frm_cnt1", int'(bus.frm_cnt1), c1);
        chk("abort_src_drained", src_q1.size(), 0);

        // Reset while waiting in DONE on byte 2 of 5.
        bus.rr_mode = 1'b0;
        for (int i = 0; i < 5; i++) add_byte(0, 8'h50 + 8'(i), i == 4, i < 2);
        exp_gnt_q.push_back(0);
        l       = tot_loads;
        bus.req = 2'b01;
        wait_for("rst_grant", 0, tot_grants + 1, 50);
        bus.req = 2'b00;
        wait_for("rst_loads", 1, l + 2, 100);
        tick(1);
        rst = 1'b1;
        tick(1);
        check_zero("mid_reset");
        rst = 1'b0;
        src_q0.delete();
        for (int i = 0; i < 40 && bus.tx_busy; i++) tick(1);
        chk("tx_idle_after_reset", int'(bus.tx_busy), 0);
        add_seq(1, 8'h61, 2);
        add_frame(1, 2, 0);
        f       = tot_frames;
        bus.req = 2'b10;
        wait_for("post_rst_grant", 0, tot_grants + 1, 50);
        bus.req = 2'b00;
        wait_for("post_rst_frame", 2, f + 1, 200);
        tick(20);

        // Single-byte frame, req dropped during SETUP.
        add_seq(0, 8'h5A, 1);
        add_frame(0, 1, 0);
        f       = tot_frames;
        bus.req = 2'b01;
        wait_for("single_grant", 0, tot_grants + 1, 50);
        bus.req = 2'b00;
        wait_for("single_frame", 2, f + 1, 200);
        tick(20);

        chk("exp_load_q_empty", exp_load_q.size(), 0);
        chk("exp_gnt_q_empty", exp_gnt_q.size(), 0);
        chk("exp_len_q_empty", exp_len_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usrt_tx_arbiter.md
Name: usrt_tx_arbiter

Overview:
- Shares the single USRT transmitter between two frame sources: button-triggered message generators 0 and 1.
- Arbitrates between pending requests, grants one source for a whole frame, and fetches its bytes one at a time.
- Loads each byte into the transmitter and drives rts around the frame.
- Sits between the message sources and the USRT transmitter in the top level; runs entirely in the clk domain.

Parameters:
- DATA_W, 8: byte width on source and transmitter interfaces.
- RTS_SETUP, 4: clk cycles rts is held high before the first tx_load.
- GAP_CYCLES, 16: idle clk cycles after rts falls before the next grant.
- MAX_BYTES, 64: byte cap per frame; the frame aborts when the cap is reached.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- rr_mode  in  1  1 = round-robin, 0 = fixed priority (source 0 wins); sampled only in IDLE.
- req  in  2  frame request per source; level, held until granted.
- src_data0  in  DATA_W  current byte of source 0.
- src_data1  in  DATA_W  current byte of source 1.
- src_last  in  2  per source: current byte is the last of the frame.
- gnt  out  2  one-hot grant; held for the whole frame.
- byte_rd  out  2  one-cycle pulse to the granted source: byte consumed, advance.
- tx_data  out  DATA_W  byte to the transmitter.
- tx_load  out  1  one-cycle load strobe to the transmitter.
- tx_busy  in  1  transmitter shifting (already synchronised to clk).
- rts  out  1  request-to-send.
- abort  out  1  one-cycle pulse when a frame is cut at MAX_BYTES.
- frm_cnt0  out  16  frames completed by source 0 (optional feature).
- frm_cnt1  out  16  frames completed by source 1 (optional feature).

Behaviour:
- Reset values: gnt=0, byte_rd=0, tx_data=0, tx_load=0, rts=0, abort=0, frm_cnt0/1=0; state=IDLE; rr pointer=source 0 preferred.
- Reset mid-frame: all outputs return to reset values on the next edge. No further tx_load is issued; a byte already in the transmitter is not recalled.
- IDLE: if req!=0, choose the winner and go to SETUP; gnt is registered and appears the cycle after the decision.
  - Fixed priority: source 0 wins whenever req[0]=1.
  - Round-robin: the preferred source wins if it requests, otherwise the other source wins.
  - The pointer flips to the non-winner at grant.
  - A source that is alone in requesting always wins in either mode.
- SETUP: rts=1, count RTS_SETUP cycles, then go to LOAD.
- LOAD: single cycle.
  - Outputs: tx_data = granted src_data, tx_load=1, byte_rd[winner]=1.
  - Capture src_last[winner]; increment the 7-bit byte counter.
  - Go to ACK.
- ACK: wait for tx_busy=1, then go to DONE. There is no timeout; tx_busy is guaranteed by the transmitter.
- DONE: wait for tx_busy=0, then:
  - If the captured last=1, go to GAP.
  - Else if byte count == MAX_BYTES, pulse abort and go to GAP.
  - Else go to LOAD.
  - Inter-byte latency is therefore 1 clk after tx_busy falls.
- GAP:
  - On entry: rts=0, gnt=0, and the granted source's frame counter increments (aborted frames are not counted).
  - Wait GAP_CYCLES, then return to IDLE.
- Deassertion of req during a granted frame is ignored; the frame completes normally.
- Requests arriving during a frame are evaluated only in IDLE.
- byte_rd and tx_load are always coincident and never asserted outside LOAD.
- A frame consisting of a single byte (last=1 on the first byte) is legal.

Optional Feature:
- USRT_ARB_STATS_EN defined: frm_cnt0/frm_cnt1 are 16-bit counters that wrap from 0xFFFF to 0x0000 and clear on rst.
- Macro undefined: counters are not synthesised; frm_cnt0/frm_cnt1 are tied to 0.

Test Plan:
- Reset, req=2'b01, 3-byte frame 0xA1,0xA2,0xA3 (last on third), tx_busy model 15 clk per byte:
  - Required: rts rises 1 clk after grant; first tx_load 4 clk after rts.
  - Required: exactly 3 tx_load with data A1,A2,A3 and 3 byte_rd[0] pulses.
  - Required: rts falls after the third busy drop; next grant is no earlier than 16 clk later.
- rr_mode=0, req=2'b11 held for 3 frames -> all 3 grants go to source 0; frm_cnt0=3, frm_cnt1=0.
- rr_mode=1, req=2'b11 held for 4 frames -> grant order 0,1,0,1; frm_cnt0=2, frm_cnt1=2.
- Source 1 never asserts last -> exactly 64 tx_load, abort pulse 1 cycle, rts falls, frm_cnt1 unchanged.
- rst asserted while in DONE on byte 2 of 5 -> next cycle all outputs 0, state IDLE; a new req=2'b10 then starts a clean frame with a fresh byte count.
- Single-byte frame 0x5A with req dropped during SETUP -> frame still sent, one tx_load, gnt clears at GAP.
